// File: rtl/rtc_ctrl_pkg.sv
// Shared definitions for the rtc_ctrl command sequencer: command codes,
// FSM state encoding, payload widths and the latched request record.
package rtc_ctrl_pkg;

   localparam int PERIOD_W = 40;
   localparam int NS_W     = 38;
   localparam int SEC_W    = 48;
   localparam int ADJ_W    = 32;

   typedef enum logic [1:0] {
      CMD_PERIOD = 2'd0,
      CMD_TIME   = 2'd1,
      CMD_ADJ    = 2'd2,
      CMD_RSVD   = 2'd3
   } cmd_e;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_ADJ = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   typedef struct packed {
      logic [1:0]          cmd;
      logic [PERIOD_W-1:0] period;
      logic [NS_W-1:0]     ns;
      logic [SEC_W-1:0]    sec;
      logic [ADJ_W-1:0]    adj_cnt;
   } req_t;

endpackage

// File: rtl/rtc_ctrl_arb.sv
// Two-way arbiter for rtc_ctrl. With RTC_CTRL_RR_EN defined the port granted
// last loses a tie (round-robin); otherwise port 0 always wins a tie.
module rtc_ctrl_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       last
);

   logic r_last;

   assign last = r_last;

`ifdef RTC_CTRL_RR_EN
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = r_last ? 2'b01 : 2'b10;
      end
   end
`else
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = 2'b01;
      end
   end
`endif

   // Doubles as the RR pointer and as the ack routing for the command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (advance && (gnt != 2'b00)) begin
         r_last <= gnt[1];
      end
   end

endmodule

// File: rtl/rtc_ctrl.sv
// Command sequencer in front of the rtc timer: arbitrates two requesters, issues
// one load strobe per command and holds off traffic during adjustments.
// Arbitration mode is selected by RTC_CTRL_RR_EN (see rtc_ctrl_arb).
module rtc_ctrl
   import rtc_ctrl_pkg::*;
#(
   parameter logic [31:0] ADJ_TIMEOUT = 32'd1000000
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                r0_req,
   input  logic [1:0]          r0_cmd,
   input  logic [PERIOD_W-1:0] r0_period,
   input  logic [NS_W-1:0]     r0_ns,
   input  logic [SEC_W-1:0]    r0_sec,
   input  logic [ADJ_W-1:0]    r0_adj_cnt,
   output logic                r0_ack,
   output logic                r0_err,

   input  logic                r1_req,
   input  logic [1:0]          r1_cmd,
   input  logic [PERIOD_W-1:0] r1_period,
   input  logic [NS_W-1:0]     r1_ns,
   input  logic [SEC_W-1:0]    r1_sec,
   input  logic [ADJ_W-1:0]    r1_adj_cnt,
   output logic                r1_ack,
   output logic                r1_err,

   output logic                period_ld,
   output logic                time_ld,
   output logic                adj_ld,
   output logic [PERIOD_W-1:0] period_in,
   output logic [NS_W-1:0]     time_reg_ns_in,
   output logic [SEC_W-1:0]    time_reg_sec_in,
   output logic [ADJ_W-1:0]    adj_ld_data,
   output logic [PERIOD_W-1:0] period_adj,
   input  logic                adj_ld_done,
   output logic                busy
);

   logic [1:0]       w_req;
   logic [1:0]       w_gnt;
   logic             w_port;
   logic             w_advance;
   req_t             w_r0;
   req_t             w_r1;
   req_t             w_sel;
   logic             w_fin;
   logic             w_fin_err;
   logic [1:0]       w_ack;
   logic [1:0]       w_err;
   logic [1:0]       r_state;
   logic [ADJ_W-1:0] r_cnt;

   assign w_req     = {r1_req, r0_req};
   assign w_advance = (r_state == ST_IDLE) && (w_req != 2'b00);
   assign w_r0      = {r0_cmd, r0_period, r0_ns, r0_sec, r0_adj_cnt};
   assign w_r1      = {r1_cmd, r1_period, r1_ns, r1_sec, r1_adj_cnt};
   assign w_sel     = w_gnt[1] ? w_r1 : w_r0;

   rtc_ctrl_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_req),
      .advance (w_advance),
      .gnt     (w_gnt),
      .last    (w_port)
   );

   // A command finishes either straight from ISSUE (no adjust strobe was
   // issued) or from WAIT_ADJ on done / timeout; done wins over timeout.
   always_comb begin
      w_fin     = 1'b0;
      w_fin_err = 1'b0;
      case (r_state)
         ST_ISSUE: begin
            if (!adj_ld) begin
               w_fin     = 1'b1;
               w_fin_err = !(period_ld || time_ld);
            end
         end
         ST_WAIT_ADJ: begin
            if (adj_ld_done) begin
               w_fin = 1'b1;
            end else if (r_cnt == (ADJ_TIMEOUT - 32'd1)) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         busy            <= 1'b0;
         period_ld       <= 1'b0;
         time_ld         <= 1'b0;
         adj_ld          <= 1'b0;
         period_in       <= '0;
         time_reg_ns_in  <= '0;
         time_reg_sec_in <= '0;
         adj_ld_data     <= '0;
         period_adj      <= '0;
      end else begin
         period_ld <= 1'b0;
         time_ld   <= 1'b0;
         adj_ld    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_advance) begin
                  r_state <= ST_ISSUE;
                  busy    <= 1'b1;
                  // Strobes are registered here so they line up with the payload.
                  case (w_sel.cmd)
                     CMD_PERIOD: begin
                        period_in <= w_sel.period;
                        period_ld <= 1'b1;
                     end
                     CMD_TIME: begin
                        time_reg_ns_in  <= w_sel.ns;
                        time_reg_sec_in <= w_sel.sec;
                        time_ld         <= 1'b1;
                     end
                     CMD_ADJ: begin
                        if (w_sel.adj_cnt != '0) begin
                           adj_ld_data <= w_sel.adj_cnt;
                           period_adj  <= w_sel.period;
                           adj_ld      <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_ISSUE: begin
               r_cnt   <= '0;
               r_state <= adj_ld ? ST_WAIT_ADJ : ST_DONE;
            end
            ST_WAIT_ADJ: begin
               if (w_fin) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT = (gi == 1);
      logic r_ack;
      logic r_err;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
         end else begin
            r_ack <= w_fin && (w_port == PORT);
            r_err <= w_fin && w_fin_err && (w_port == PORT);
         end
      end

      assign w_ack[gi] = r_ack;
      assign w_err[gi] = r_err;
   end

   assign r0_ack = w_ack[0];
   assign r1_ack = w_ack[1];
   assign r0_err = w_err[0];
   assign r1_err = w_err[1];

endmodule

// File: tb/tb_rtc_ctrl.sv
// Self-checking bench for rtc_ctrl: directed scenarios plus randomized single
// commands checked against transaction-level expectations.
module tb_rtc_ctrl;
   import rtc_ctrl_pkg::*;

   localparam int TO = 128;
`ifdef RTC_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r1_req;
   logic [1:0]  r0_cmd, r1_cmd;
   logic [39:0] r0_period, r1_period;
   logic [37:0] r0_ns, r1_ns;
   logic [47:0] r0_sec, r1_sec;
   logic [31:0] r0_adj_cnt, r1_adj_cnt;
   logic        r0_ack, r0_err, r1_ack, r1_err;
   logic        period_ld, time_ld, adj_ld;
   logic [39:0] period_in, period_adj;
   logic [37:0] time_reg_ns_in;
   logic [47:0] time_reg_sec_in;
   logic [31:0] adj_ld_data;
   logic        adj_ld_done;
   logic        busy;

   int checks    = 0;
   int failures  = 0;
   int last_port = 1;

   always #5 clk = ~clk;

   rtc_ctrl #(.ADJ_TIMEOUT(32'(TO))) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_period(r0_period), .r0_ns(r0_ns),
      .r0_sec(r0_sec), .r0_adj_cnt(r0_adj_cnt), .r0_ack(r0_ack), .r0_err(r0_err),
      .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_period(r1_period), .r1_ns(r1_ns),
      .r1_sec(r1_sec), .r1_adj_cnt(r1_adj_cnt), .r1_ack(r1_ack), .r1_err(r1_err),
      .period_ld(period_ld), .time_ld(time_ld), .adj_ld(adj_ld),
      .period_in(period_in), .time_reg_ns_in(time_reg_ns_in),
      .time_reg_sec_in(time_reg_sec_in), .adj_ld_data(adj_ld_data),
      .period_adj(period_adj), .adj_ld_done(adj_ld_done), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_req(input int port, input logic [1:0] cmd, input logic [39:0] per,
                            input logic [37:0] ns, input logic [47:0] sec, input logic [31:0] cnt);
      if (port == 0) begin
         r0_req = 1'b1; r0_cmd = cmd; r0_period = per; r0_ns = ns; r0_sec = sec; r0_adj_cnt = cnt;
      end else begin
         r1_req = 1'b1; r1_cmd = cmd; r1_period = per; r1_ns = ns; r1_sec = sec; r1_adj_cnt = cnt;
      end
   endtask

   task automatic drop_req(input int port);
      if (port == 0) r0_req = 1'b0;
      else           r1_req = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 64'({period_ld, time_ld, adj_ld, r0_ack, r1_ack, r0_err, r1_err, busy}), 64'd0);
      chk({tag, "_period_in"}, 64'(period_in), 64'd0);
      chk({tag, "_period_adj"}, 64'(period_adj), 64'd0);
      chk({tag, "_adj_data"}, 64'(adj_ld_data), 64'd0);
      chk({tag, "_ns"}, 64'(time_reg_ns_in), 64'd0);
      chk({tag, "_sec"}, 64'(time_reg_sec_in), 64'd0);
   endtask

   // One command from a single requester, starting in an IDLE cycle. adj_ld_done
   // is driven high for step indices done_from..done_to (done_from = 0: never).
   task automatic run_single(input string tag, input int port, input logic [1:0] cmd,
                             input logic [39:0] per, input logic [37:0] ns, input logic [47:0] sec,
                             input logic [31:0] cnt, input int done_from, input int done_to);
      int exp_kind, exp_ack, d_eff, ack_at, strobe_at, n_strobe, got_kind, ack_port, busy_low;
      logic exp_err, got_err;
      // kind: 0 none, 1 period, 2 time, 3 adjust
      exp_kind = (cmd == CMD_PERIOD) ? 1 : (cmd == CMD_TIME) ? 2 :
                 ((cmd == CMD_ADJ) && (cnt != 0)) ? 3 : 0;
      d_eff = (done_from < 2) ? 2 : done_from;
      if (exp_kind == 3) begin
         if ((done_from > 0) && (done_to >= d_eff) && (d_eff <= TO + 1)) begin
            exp_ack = d_eff + 1; exp_err = 1'b0;
         end else begin
            exp_ack = TO + 2;    exp_err = 1'b1;
         end
      end else begin
         exp_ack = 2; exp_err = (exp_kind == 0);
      end
      ack_at = -1; strobe_at = -1; n_strobe = 0; got_kind = 0; ack_port = -1;
      busy_low = 0; got_err = 1'bx;
      drive_req(port, cmd, per, ns, sec, cnt);
      for (int k = 1; (k <= TO + 20) && (ack_at < 0); k++) begin
         step();
         if (busy !== 1'b1) busy_low++;
         if (period_ld || time_ld || adj_ld) begin
            n_strobe++;
            strobe_at = k;
            got_kind  = period_ld ? 1 : time_ld ? 2 : 3;
            if (got_kind == 1) chk({tag, "_period_in"}, 64'(period_in), 64'(per));
            if (got_kind == 2) begin
               chk({tag, "_ns"}, 64'(time_reg_ns_in), 64'(ns));
               chk({tag, "_sec"}, 64'(time_reg_sec_in), 64'(sec));
            end
            if (got_kind == 3) begin
               chk({tag, "_adj_data"}, 64'(adj_ld_data), 64'(cnt));
               chk({tag, "_period_adj"}, 64'(period_adj), 64'(per));
            end
         end
         if (r0_ack || r1_ack) begin
            ack_at   = k;
            ack_port = r1_ack ? 1 : 0;
            got_err  = r1_ack ? r1_err : r0_err;
            drop_req(port);
         end
         adj_ld_done = (done_from > 0) && (k >= done_from) && (k <= done_to);
      end
      adj_ld_done = 1'b0;
      chk({tag, "_strobe_kind"}, 64'(got_kind), 64'(exp_kind));
      chk({tag, "_strobe_count"}, 64'(n_strobe), 64'(exp_kind != 0));
      if (exp_kind != 0) chk({tag, "_strobe_cycle"}, 64'(strobe_at), 64'd1);
      chk({tag, "_ack_cycle"}, 64'(ack_at), 64'(exp_ack));
      chk({tag, "_ack_port"}, 64'(ack_port), 64'(port));
      chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
      chk({tag, "_busy_during"}, 64'(busy_low), 64'd0);
      step();
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
      last_port = port;
      $display("txn %s port=%0d cmd=%0d cnt=%0d ack_at=%0d err=%0b", tag, port, cmd, cnt, ack_at, got_err);
   endtask

   initial begin
      int t_ld, a0, a1, got, exp_p, early_ack;
      int port, dfrom, dto;
      logic [1:0]  cmd;
      logic [31:0] cnt;
      logic [63:0] rnd;
      logic [39:0] seen_per;

      rst = 1'b1; adj_ld_done = 1'b0;
      r0_req = 1'b0; r0_cmd = 2'd0; r0_period = '0; r0_ns = '0; r0_sec = '0; r0_adj_cnt = '0;
      r1_req = 1'b0; r1_cmd = 2'd0; r1_period = '0; r1_ns = '0; r1_sec = '0; r1_adj_cnt = '0;
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;
      last_port = 1;
      step();

      run_single("p0_period", 0, CMD_PERIOD, 40'h08_00000000, 38'd0, 48'd0, 32'd0, 0, 0);
      run_single("p1_adjust", 1, CMD_ADJ, 40'hfb_00000000, 38'd0, 48'd0, 32'd100, 100, 100);
      run_single("timeout", 0, CMD_ADJ, 40'h07_80000000, 38'd0, 48'd0, 32'd5, 0, 0);
      run_single("rsvd", 1, CMD_RSVD, 40'h1, 38'd2, 48'd3, 32'd4, 0, 0);
      run_single("cnt_zero", 0, CMD_ADJ, 40'h1, 38'd2, 48'd3, 32'd0, 0, 0);
      run_single("done_in_issue", 1, CMD_ADJ, 40'h5, 38'd0, 48'd0, 32'd9, 1, 1);
      run_single("done_level", 1, CMD_ADJ, 40'h6, 38'd0, 48'd0, 32'd9, 1, 3);

      // Time load from port 0 arrives while port 1's adjust is in flight.
      t_ld = -1; a0 = -1; a1 = -1;
      drive_req(1, CMD_ADJ, 40'hfb_00000000, 38'd0, 48'd0, 32'd5);
      for (int k = 1; (k <= 40) && (a0 < 0); k++) begin
         step();
         if (k == 1) chk("serial_adj_strobe", 64'(adj_ld), 64'd1);
         if (time_ld && (t_ld < 0)) begin
            t_ld = k;
            chk("serial_sec", 64'(time_reg_sec_in), 64'd10);
            chk("serial_ns", 64'(time_reg_ns_in), 64'd1000);
         end
         if (r1_ack) begin a1 = k; drop_req(1); end
         if (r0_ack) begin a0 = k; drop_req(0); end
         if (k == 2) drive_req(0, CMD_TIME, 40'd0, 38'd1000, 48'd10, 32'd0);
         adj_ld_done = (k == 10);
      end
      adj_ld_done = 1'b0;
      chk("serial_r1_ack", 64'(a1), 64'd11);
      chk("serial_time_ld", 64'(t_ld), 64'd13);
      chk("serial_r0_ack", 64'(a0), 64'd14);
      step();
      last_port = 0;
      $display("txn serial r1_ack=%0d time_ld=%0d r0_ack=%0d", a1, t_ld, a0);

      // Reset in WAIT_ADJ: everything clears, no ack, held request re-issued.
      early_ack = 0;
      drive_req(1, CMD_ADJ, 40'h0a_00000000, 38'd0, 48'd0, 32'd7);
      for (int k = 1; k <= 3; k++) begin
         step();
         if (r0_ack || r1_ack) early_ack++;
      end
      rst = 1'b1;
      step();
      if (r0_ack || r1_ack) early_ack++;
      chk_zero("rst_mid");
      chk("rst_no_ack", 64'(early_ack), 64'd0);
      rst = 1'b0;
      last_port = 1;
      run_single("rst_reissue", 1, CMD_ADJ, 40'h0a_00000000, 38'd0, 48'd0, 32'd7, 2, 2);

      // Both ports hold period requests continuously for four commands.
      drive_req(0, CMD_PERIOD, 40'h11_00000000, 38'd0, 48'd0, 32'd0);
      drive_req(1, CMD_PERIOD, 40'h22_00000000, 38'd0, 48'd0, 32'd0);
      for (int g = 0; g < 4; g++) begin
         exp_p = RR ? (1 - last_port) : 0;
         got = -1; seen_per = '0;
         for (int k = 0; (k < 10) && (got < 0); k++) begin
            step();
            if (period_ld) seen_per = period_in;
            if (r0_ack || r1_ack) got = r1_ack ? 1 : 0;
         end
         chk("tie_port", 64'(got), 64'(exp_p));
         chk("tie_payload", 64'(seen_per), (exp_p == 1) ? 64'h22_00000000 : 64'h11_00000000);
         last_port = exp_p;
         $display("txn tie grant=%0d port=%0d", g, got);
      end
      drop_req(0); drop_req(1);
      step();

      for (int i = 0; i < 30; i++) begin
         port = int'($urandom_range(0, 1));
         cmd  = 2'($urandom_range(0, 3));
         cnt  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
         if ($urandom_range(0, 5) == 0) begin
            dfrom = 0; dto = 0;
         end else begin
            dfrom = int'($urandom_range(1, 40));
            dto   = dfrom + int'($urandom_range(0, 2));
         end
         rnd = {$urandom(), $urandom()};
         run_single("rand", port, cmd, rnd[39:0], rnd[63:26], {rnd[47:0]}, cnt, dfrom, dto);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
